sr_latch_driver: RTL and testbench
==================================

Name: sr_latch_driver

Overview:
Synchronous front end that drives the set/reset/preset_/preclear_ inputs of the asynchronous SR latch with preset/preclear.
- Initializes the latch after reset, then executes set/reset/toggle commands over a soc/eoc handshake.
- Drives s/r pulses of fixed width and checks the latch feedback (q, qN) before signalling completion.
- Sits between the clocked control logic and the latch.

Parameters:
PULSE_W, 2, cycles s or r held high per command (1..15)
SETTLE_MAX, 6, cycles allowed after pulse for feedback to match (1..15)
INIT_W, 3, cycles preset_/preclear_ held asserted after reset release (1..15)
INIT_VAL, 0, initial latch state imposed: 0 = preclear_ low, 1 = preset_ low

Ports:
clock  input  1  system clock, rising edge
reset_  input  1  asynchronous reset, active low
soc  input  1  start of command
cmd  input  2  00 nop, 01 set, 10 reset, 11 toggle; sampled on soc acceptance
q_fb  input  1  latch q feedback (synchronized internally, 2 flops)
qN_fb  input  1  latch qN feedback (synchronized internally, 2 flops)
eoc  output  1  end of command; 1 = idle/ready
s  output  1  latch set input
r  output  1  latch reset input
preset_  output  1  latch preset, active low
preclear_  output  1  latch preclear, active low
err  output  1  sticky: feedback mismatch or timeout on last command
state_q  output  1  driver's record of latch state

Behaviour:
- Clock is clock; reset is reset_, asynchronous, active low. All flops clear immediately when reset_=0.
- Outputs during reset: eoc=0, s=0, r=0, err=0, state_q=INIT_VAL. preset_=~INIT_VAL and preclear_=INIT_VAL, so the init level is already applied while reset_=0.
- preset_ and preclear_ are never both 0 in any state; s and r are never both 1.
- FSM states: INIT, IDLE, PULSE, SETTLE, WAITLOW.
- INIT: entered on reset. Holds the init pin low for INIT_W cycles after reset_ release. Then releases both pins to 1 and goes to IDLE.
- IDLE: eoc=1. If soc=1, latch cmd and compute target (set→1, reset→0, toggle→~state_q).
  - nop: no pulse; go to WAITLOW.
  - any other cmd: eoc←0 next cycle and go to PULSE.
- PULSE: assert s (target 1) or r (target 0) for exactly PULSE_W cycles. A pulse is issued even if target equals state_q. Then go to SETTLE.
- SETTLE: s=r=0. Each cycle, compare synchronized (q_fb, qN_fb) with (target, ~target).
  - Match: state_q←target, err←0, go to WAITLOW.
  - No match after SETTLE_MAX cycles: err←1, state_q←target, go to WAITLOW.
- WAITLOW: eoc=1. Wait for soc=0, then go to IDLE. A soc held high never launches a second command.
- Command latency (set/reset, match on first SETTLE cycle): soc sampled at edge 0; s high edges 1..PULSE_W; eoc=1 after PULSE_W+2 edges plus synchronizer delay.
- cmd changes while busy are ignored. soc during INIT is ignored until IDLE is reached.
- reset_ asserted mid-PULSE: s/r drop asynchronously, init pin asserts, FSM returns to INIT.
- Counters saturate and never wrap (4-bit).

Optional Feature:
Macro CMD_COUNT_EN.
- Defined: extra output cmd_cnt[7:0]. Increments on each completed non-nop command (SETTLE exit), wraps 255→0, and clears on reset.
- Undefined: port and counter absent; all other behaviour is identical.

Decomposition:
- Package sr_drv_pkg: cmd encodings CMD_NOP/SET/RST/TGL, FSM state encodings, counter width constant CNT_W=4.
- One sub-module, sr_drv_timer: loadable 4-bit down counter with zero flag. Shared by INIT, PULSE and SETTLE timing.
- The 2-flop synchronizer is inline.

Test Plan:
1. Reset with INIT_VAL=0, release → preclear_=0 for 3 cycles, preset_=1, then both 1; eoc=1; state_q=0.
2. soc=1, cmd=01, latch model follows → s=1 for 2 cycles, r=0; eoc returns 1; state_q=1; err=0.
3. From state 1, cmd=11 → r pulse 2 cycles; state_q=0. Hold soc high afterwards → no second pulse until soc=0 then 1.
4. Feedback stuck (q_fb=0, qN_fb=1), cmd=01 → after 6 SETTLE cycles err=1, eoc=1. Next successful cmd=10 → err=0.
5. reset_ pulled low during PULSE cycle 1 → s=0 immediately, preclear_=0, eoc=0. FSM restarts INIT.
6. With CMD_COUNT_EN: three set/reset commands plus one nop → cmd_cnt=3.

Source files
------------

// File: rtl/sr_drv_pkg.sv
// Shared constants for the SR latch driver: command codes, FSM states, timer width.
package sr_drv_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_SET = 2'b01;
  localparam logic [1:0] CMD_RST = 2'b10;
  localparam logic [1:0] CMD_TGL = 2'b11;

  localparam logic [2:0] ST_INIT    = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_PULSE   = 3'd2;
  localparam logic [2:0] ST_SETTLE  = 3'd3;
  localparam logic [2:0] ST_WAITLOW = 3'd4;

  // Latch level a command drives towards, given the currently recorded state.
  function automatic logic cmd_target(input logic [1:0] c, input logic cur);
    logic t;
    case (c)
      CMD_SET: t = 1'b1;
      CMD_RST: t = 1'b0;
      default: t = ~cur;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/sr_drv_timer.sv
// Loadable saturating down counter with zero flag; times INIT, PULSE and SETTLE.
module sr_drv_timer
  import sr_drv_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load has priority; decrement stops at zero rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register; reset value preloads the first (INIT) interval.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) cnt_q <= RST_VAL;
    else         cnt_q <= cnt_d;
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Clocked driver for an asynchronous SR latch with preset/preclear.
// Optional build macro CMD_COUNT_EN adds the cmd_cnt completed-command counter.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int unsigned PULSE_W    = 2,
  parameter int unsigned SETTLE_MAX = 6,
  parameter int unsigned INIT_W     = 3,
  parameter bit          INIT_VAL   = 1'b0
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic       soc,
  input  logic [1:0] cmd,
  input  logic       q_fb,
  input  logic       qN_fb,
  output logic       eoc,
  output logic       s,
  output logic       r,
  output logic       preset_,
  output logic       preclear_,
  output logic       err,
  output logic       state_q
`ifdef CMD_COUNT_EN
  ,
  output logic [7:0] cmd_cnt
`endif
);

  logic [2:0] fsm_q, fsm_d;
  logic       eoc_q, eoc_d;
  logic       s_q, s_d;
  logic       r_q, r_d;
  logic       preset_q, preset_d;
  logic       preclear_q, preclear_d;
  logic       err_q, err_d;
  logic       latch_q, latch_d;
  logic       target_q, target_d;
  logic       q_s1_q, q_s2_q, qn_s1_q, qn_s2_q;
  logic       tmr_load_c, tmr_dec_c, tmr_zero_c;
  logic [CNT_W-1:0] tmr_val_c;
  logic       done_c;

  sr_drv_timer #(
    .RST_VAL (CNT_W'(INIT_W - 1))
  ) u_timer (
    .clock    (clock),
    .reset_   (reset_),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .dec      (tmr_dec_c),
    .zero_c   (tmr_zero_c)
  );

  // Two-flop synchronizers for the asynchronous latch feedback.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      q_s1_q  <= INIT_VAL;
      q_s2_q  <= INIT_VAL;
      qn_s1_q <= ~INIT_VAL;
      qn_s2_q <= ~INIT_VAL;
    end else begin
      q_s1_q  <= q_fb;
      q_s2_q  <= q_s1_q;
      qn_s1_q <= qN_fb;
      qn_s2_q <= qn_s1_q;
    end
  end

  // Next-state and next-output logic for the command sequencer.
  always_comb begin
    fsm_d      = fsm_q;
    eoc_d      = eoc_q;
    s_d        = s_q;
    r_d        = r_q;
    preset_d   = preset_q;
    preclear_d = preclear_q;
    err_d      = err_q;
    latch_d    = latch_q;
    target_d   = target_q;
    tmr_load_c = 1'b0;
    tmr_val_c  = '0;
    tmr_dec_c  = 1'b0;
    done_c     = 1'b0;
    case (fsm_q)
      ST_INIT: begin
        if (tmr_zero_c) begin
          preset_d   = 1'b1;
          preclear_d = 1'b1;
          eoc_d      = 1'b1;
          fsm_d      = ST_IDLE;
        end else begin
          tmr_dec_c = 1'b1;
        end
      end
      ST_IDLE: begin
        if (soc) begin
          if (cmd == CMD_NOP) begin
            fsm_d = ST_WAITLOW;
          end else begin
            target_d   = cmd_target(cmd, latch_q);
            s_d        = target_d;
            r_d        = ~target_d;
            eoc_d      = 1'b0;
            tmr_load_c = 1'b1;
            tmr_val_c  = CNT_W'(PULSE_W - 1);
            fsm_d      = ST_PULSE;
          end
        end
      end
      ST_PULSE: begin
        if (tmr_zero_c) begin
          s_d        = 1'b0;
          r_d        = 1'b0;
          tmr_load_c = 1'b1;
          tmr_val_c  = CNT_W'(SETTLE_MAX - 1);
          fsm_d      = ST_SETTLE;
        end else begin
          tmr_dec_c = 1'b1;
        end
      end
      ST_SETTLE: begin
        if ((q_s2_q == target_q) && (qn_s2_q == ~target_q)) begin
          latch_d = target_q;
          err_d   = 1'b0;
          eoc_d   = 1'b1;
          done_c  = 1'b1;
          fsm_d   = ST_WAITLOW;
        end else if (tmr_zero_c) begin
          latch_d = target_q;
          err_d   = 1'b1;
          eoc_d   = 1'b1;
          done_c  = 1'b1;
          fsm_d   = ST_WAITLOW;
        end else begin
          tmr_dec_c = 1'b1;
        end
      end
      ST_WAITLOW: begin
        if (!soc) fsm_d = ST_IDLE;
      end
      default: begin
        s_d        = 1'b0;
        r_d        = 1'b0;
        preset_d   = 1'b1;
        preclear_d = 1'b1;
        eoc_d      = 1'b1;
        fsm_d      = ST_IDLE;
      end
    endcase
  end

  // State and output registers; the init level is applied while reset_ is low.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      fsm_q      <= ST_INIT;
      eoc_q      <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      preset_q   <= ~INIT_VAL;
      preclear_q <= INIT_VAL;
      err_q      <= 1'b0;
      latch_q    <= INIT_VAL;
      target_q   <= INIT_VAL;
    end else begin
      fsm_q      <= fsm_d;
      eoc_q      <= eoc_d;
      s_q        <= s_d;
      r_q        <= r_d;
      preset_q   <= preset_d;
      preclear_q <= preclear_d;
      err_q      <= err_d;
      latch_q    <= latch_d;
      target_q   <= target_d;
    end
  end

`ifdef CMD_COUNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Completed non-nop command counter, wraps naturally at 8 bits.
  always_comb begin
    cnt_d = cnt_q;
    if (done_c) cnt_d = cnt_q + 8'd1;
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) cnt_q <= 8'd0;
    else         cnt_q <= cnt_d;
  end

  assign cmd_cnt = cnt_q;
`else
  logic unused_done;
  assign unused_done = done_c;
`endif

  assign eoc       = eoc_q;
  assign s         = s_q;
  assign r         = r_q;
  assign preset_   = preset_q;
  assign preclear_ = preclear_q;
  assign err       = err_q;
  assign state_q   = latch_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench for sr_latch_driver with a behavioural SR latch on the pins.
module tb_sr_latch_driver;

  localparam int unsigned PW = 2;
  localparam int unsigned SM = 6;
  localparam int unsigned IW = 3;

  logic       clock = 1'b0;
  logic       reset_ = 1'b1;
  logic       soc = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic       q_fb, qN_fb;
  logic       eoc, s, r, preset_, preclear_, err, state_q;
`ifdef CMD_COUNT_EN
  logic [7:0] cmd_cnt;
`endif

  logic latch_v = 1'b0;
  logic stuck = 1'b0;
  logic stuck_val = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model: the driver's expected record of the latch and its status.
  logic   m_state = 1'b0;
  logic   m_err = 1'b0;
  int     m_cnt = 0;

  sr_latch_driver #(
    .PULSE_W    (PW),
    .SETTLE_MAX (SM),
    .INIT_W     (IW),
    .INIT_VAL   (1'b0)
  ) dut (
    .clock     (clock),
    .reset_    (reset_),
    .soc       (soc),
    .cmd       (cmd),
    .q_fb      (q_fb),
    .qN_fb     (qN_fb),
    .eoc       (eoc),
    .s         (s),
    .r         (r),
    .preset_   (preset_),
    .preclear_ (preclear_),
    .err       (err),
    .state_q   (state_q)
`ifdef CMD_COUNT_EN
    ,
    .cmd_cnt   (cmd_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Asynchronous SR latch with dominant preset/preclear.
  always @(s or r or preset_ or preclear_) begin
    if (!preset_)        latch_v = 1'b1;
    else if (!preclear_) latch_v = 1'b0;
    else if (s)          latch_v = 1'b1;
    else if (r)          latch_v = 1'b0;
  end

  assign q_fb  = stuck ? stuck_val : latch_v;
  assign qN_fb = ~q_fb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Measures how long the init pin is held after reset_ release, then checks idle state.
  task automatic check_init(input string tag);
    int cycles = 1;
    int early_eoc = 0;
    int bad_preset = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (preclear_ === 1'b1) break;
      cycles++;
      if (eoc !== 1'b0) early_eoc++;
      if (preset_ !== 1'b1) bad_preset++;
    end
    chk({tag, "_init_len"}, cycles, IW);
    chk({tag, "_init_eoc"}, early_eoc, 0);
    chk({tag, "_init_preset"}, bad_preset, 0);
    @(negedge clock);
    chk({tag, "_idle_eoc"}, eoc, 1);
    chk({tag, "_idle_pins"}, {preset_, preclear_}, 2'b11);
    chk({tag, "_idle_state"}, state_q, 0);
    chk({tag, "_idle_err"}, err, 0);
  endtask

  // Issues one command with soc held high over a long window, then compares with the model.
  task automatic run_cmd(input logic [1:0] c, input logic stk, input logic stk_val);
    int s_cnt = 0, r_cnt = 0, busy = 0, both = 0, pins_bad = 0;
    int exp_s, exp_r, exp_busy;
    logic tgt, mism;
    stuck = stk;
    stuck_val = stk_val;
    repeat (3) @(negedge clock);
    soc = 1'b1;
    cmd = c;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      cmd = 2'($urandom);
      if (s === 1'b1) s_cnt++;
      if (r === 1'b1) r_cnt++;
      if (s === 1'b1 && r === 1'b1) both++;
      if (preset_ === 1'b0 && preclear_ === 1'b0) pins_bad++;
      if (eoc !== 1'b1) busy++;
    end
    soc = 1'b0;
    @(negedge clock);
    if (c == 2'b00) begin
      exp_s = 0; exp_r = 0; exp_busy = 0;
    end else begin
      tgt = (c == 2'b01) ? 1'b1 : (c == 2'b10) ? 1'b0 : ~m_state;
      mism = stk && (stk_val != tgt);
      exp_s = tgt ? PW : 0;
      exp_r = tgt ? 0 : PW;
      exp_busy = mism ? (PW + SM) : (PW + 1);
      m_state = tgt;
      m_err = mism;
      m_cnt = (m_cnt + 1) % 256;
    end
    chk($sformatf("cmd%0d_s_cycles", c), s_cnt, exp_s);
    chk($sformatf("cmd%0d_r_cycles", c), r_cnt, exp_r);
    chk($sformatf("cmd%0d_busy", c), busy, exp_busy);
    chk($sformatf("cmd%0d_sr_both", c), both, 0);
    chk($sformatf("cmd%0d_pins_both_low", c), pins_bad, 0);
    chk($sformatf("cmd%0d_state", c), state_q, m_state);
    chk($sformatf("cmd%0d_err", c), err, m_err);
    chk($sformatf("cmd%0d_eoc", c), eoc, 1);
`ifdef CMD_COUNT_EN
    chk($sformatf("cmd%0d_cnt", c), cmd_cnt, m_cnt);
`endif
  endtask

  initial begin
    // Reset held: init level applied, outputs at reset values.
    #1 reset_ = 1'b0;
    soc = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_eoc", eoc, 0);
    chk("rst_sr", {s, r}, 2'b00);
    chk("rst_err", err, 0);
    chk("rst_state", state_q, 0);
    chk("rst_pins", {preset_, preclear_}, 2'b10);
    // soc held during INIT must not start anything; drop it at release.
    reset_ = 1'b1;
    soc = 1'b0;
    check_init("boot");

    // Directed: set, toggle, stuck feedback, recovery, nop.
    run_cmd(2'b01, 1'b0, 1'b0);
    run_cmd(2'b11, 1'b0, 1'b0);
    run_cmd(2'b01, 1'b1, 1'b0);
    run_cmd(2'b10, 1'b0, 1'b0);
    run_cmd(2'b00, 1'b0, 1'b0);
    run_cmd(2'b10, 1'b0, 1'b0);

    // Randomized commands, occasionally with stuck feedback.
    for (int k = 0; k < 24; k++) begin
      run_cmd(2'($urandom), ($urandom_range(0, 4) == 0), 1'($urandom));
    end

    // Reset during the first pulse cycle.
    stuck = 1'b0;
    @(negedge clock);
    soc = 1'b1;
    cmd = 2'b01;
    @(posedge clock);
    #1 chk("midrst_pulse_s", s, 1);
    #2 reset_ = 1'b0;
    #1;
    chk("midrst_s", s, 0);
    chk("midrst_pins", {preset_, preclear_}, 2'b10);
    chk("midrst_eoc", eoc, 0);
    chk("midrst_state", state_q, 0);
    @(negedge clock);
    soc = 1'b0;
    reset_ = 1'b1;
    m_state = 1'b0;
    m_err = 1'b0;
    m_cnt = 0;
    check_init("rerun");
    run_cmd(2'b01, 1'b0, 1'b0);
    run_cmd(2'b11, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
